// File: rtl/calc_result_display.sv
// calc_result_display: captures a result word, converts it to BCD with a
// sequential double-dabble engine and drives a multiplexed 4-digit display.
// Optional signed mode is enabled by defining CALC_SIGNED_EN.
module calc_result_display #(
    parameter int DW          = 8,
    parameter int REFRESH_DIV = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done,
    input  logic [DW-1:0] result,
    output logic          busy,
    output logic          valid,
    output logic [11:0]   bcd,
    output logic [3:0]    an,
    output logic [6:0]    seg
);

`ifdef CALC_SIGNED_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif
    localparam int SW = 12 + NB;
    localparam int CW = $clog2(NB + 1);
    localparam int RW = $clog2(REFRESH_DIV);

    localparam logic [6:0] BLANK = 7'b1111111;
`ifdef CALC_SIGNED_EN
    localparam logic [6:0] MINUS = 7'b0111111;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WRITE
    } state_t;

    state_t         state_q;
    logic [SW-1:0]  sr_q;
    logic [CW-1:0]  cnt_q;
    logic           pend_q;
    logic [DW-1:0]  pbuf_q;
    logic           busy_q;
    logic           valid_q;
    logic [11:0]    bcd_q;
`ifdef CALC_SIGNED_EN
    logic           sign_cur_q;
    logic           sign_q;
`endif

    logic [RW-1:0]  rcnt_q;
    logic [1:0]     dig_q;
    logic [3:0]     an_q;
    logic [6:0]     seg_q;
    logic [6:0]     seg_d;

    // Magnitude of the loaded word, widened to the engine width.
    function automatic logic [NB-1:0] to_mag(input logic [DW-1:0] v);
`ifdef CALC_SIGNED_EN
        logic [NB-1:0] ext;
        ext = {v[DW-1], v};
        return v[DW-1] ? (~ext + NB'(1)) : ext;
`else
        return v;
`endif
    endfunction

    // One double-dabble step: correct each BCD nibble, then shift left.
    function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[NB+4*i +: 4] >= 4'd5)
                t[NB+4*i +: 4] = t[NB+4*i +: 4] + 4'd3;
        end
        return {t[SW-2:0], 1'b0};
    endfunction

    // Active-low glyph for one BCD digit.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        unique case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = BLANK;
        endcase
        return g;
    endfunction

    // Conversion FSM with one-deep pending buffer; a pending word restarts
    // the engine at the WRITE edge so busy never drops between conversions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pbuf_q     <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
`ifdef CALC_SIGNED_EN
            sign_cur_q <= 1'b0;
            sign_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (done) begin
                        sr_q       <= {12'b0, to_mag(result)};
                        cnt_q      <= CW'(NB);
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
`ifdef CALC_SIGNED_EN
                        sign_cur_q <= result[DW-1];
`endif
                    end
                end
                SHIFT: begin
                    sr_q  <= dabble(sr_q);
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_q <= WRITE;
                    if (done) begin
                        pbuf_q <= result;
                        pend_q <= 1'b1;
                    end
                end
                WRITE: begin
                    bcd_q   <= sr_q[SW-1 -: 12];
                    valid_q <= 1'b1;
`ifdef CALC_SIGNED_EN
                    sign_q  <= sign_cur_q;
`endif
                    if (pend_q) begin
                        sr_q       <= {12'b0, to_mag(pbuf_q)};
                        cnt_q      <= CW'(NB);
                        state_q    <= SHIFT;
`ifdef CALC_SIGNED_EN
                        sign_cur_q <= pbuf_q[DW-1];
`endif
                        if (done)
                            pbuf_q <= result;
                        else
                            pend_q <= 1'b0;
                    end else if (done) begin
                        sr_q       <= {12'b0, to_mag(result)};
                        cnt_q      <= CW'(NB);
                        state_q    <= SHIFT;
`ifdef CALC_SIGNED_EN
                        sign_cur_q <= result[DW-1];
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Refresh timer: advance the lit digit every REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q <= '0;
            dig_q  <= '0;
        end else if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
            rcnt_q <= '0;
            dig_q  <= dig_q + 2'd1;
        end else begin
            rcnt_q <= rcnt_q + RW'(1);
        end
    end

    // Segment pattern for the current digit with leading-zero blanking.
    always_comb begin
        seg_d = BLANK;
        unique case (dig_q)
            2'd0: seg_d = glyph(bcd_q[3:0]);
            2'd1: seg_d = (bcd_q[11:4] == 8'd0) ? BLANK : glyph(bcd_q[7:4]);
            2'd2: seg_d = (bcd_q[11:8] == 4'd0) ? BLANK : glyph(bcd_q[11:8]);
            2'd3: begin
`ifdef CALC_SIGNED_EN
                seg_d = sign_q ? MINUS : BLANK;
`else
                seg_d = BLANK;
`endif
            end
            default: seg_d = BLANK;
        endcase
    end

    // Registered display drive; dark until the first result is ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= 4'b1111;
            seg_q <= BLANK;
        end else if (valid_q) begin
            an_q  <= ~(4'b0001 << dig_q);
            seg_q <= seg_d;
        end else begin
            an_q  <= 4'b1111;
            seg_q <= BLANK;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign bcd   = bcd_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Self-checking bench for calc_result_display: directed plus random results
// compared against an arithmetic decimal/glyph model.
module tb_calc_result_display;

    localparam int DW = 8;
    localparam int RD = 16;
`ifdef CALC_SIGNED_EN
    localparam int LAT = DW + 2;
`else
    localparam int LAT = DW + 1;
`endif
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;
    localparam logic [6:0] GLY [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic          clk;
    logic          rst;
    logic          done;
    logic [DW-1:0] result;
    logic          busy;
    logic          valid;
    logic [11:0]   bcd;
    logic [3:0]    an;
    logic [6:0]    seg;

    int checks = 0;
    int errors = 0;

    calc_result_display #(.DW(DW), .REFRESH_DIV(RD)) dut (
        .clk    (clk),
        .rst    (rst),
        .done   (done),
        .result (result),
        .busy   (busy),
        .valid  (valid),
        .bcd    (bcd),
        .an     (an),
        .seg    (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Magnitude and sign of a result word as the calculator means it.
    function automatic int mag(input logic [DW-1:0] v);
        int m;
        m = int'(v);
`ifdef CALC_SIGNED_EN
        if (v[DW-1]) m = (1 << DW) - m;
`endif
        return m;
    endfunction

    function automatic bit neg(input logic [DW-1:0] v);
`ifdef CALC_SIGNED_EN
        return v[DW-1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [11:0] to_bcd(input int m);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int d, input int m,
                                           input bit n);
        int h, t, o;
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
        if (d == 0) return GLY[o];
        if (d == 1) return (h == 0 && t == 0) ? BL : GLY[t];
        if (d == 2) return (h == 0) ? BL : GLY[h];
        return n ? MI : BL;
    endfunction

    task automatic convert(input logic [DW-1:0] v);
        int n;
        @(negedge clk);
        done = 1'b1;
        result = v;
        @(negedge clk);
        done = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("latency", n, LAT);
        chk("bcd", bcd, to_bcd(mag(v)));
        chk("valid", valid, 1);
    endtask

    task automatic display(input logic [DW-1:0] v);
        int idx;
        logic [3:0] prev;
        int run;
        bit seen;
        repeat (2) @(negedge clk);
        prev = an;
        run = 0;
        seen = 0;
        for (int c = 0; c < 5 * RD + 2; c++) begin
            idx = -1;
            for (int i = 0; i < 4; i++)
                if (an == ~(4'b0001 << i)) idx = i;
            chk("an_onehot", idx >= 0, 1);
            if (idx >= 0)
                chk($sformatf("seg_d%0d", idx), seg,
                    exp_seg(idx, mag(v), neg(v)));
            if (an == prev) begin
                run++;
            end else begin
                if (seen) chk("hold", run, RD);
                seen = 1;
                run = 1;
                prev = an;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [DW-1:0] r;
        int bc, rises;
        bit prevb, bad17;

        rst = 1'b0;
        done = 1'b0;
        result = '0;
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, BL);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_bcd", bcd, 12'h000);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_an", an, 4'b1111);

        convert(8'd237);
        display(8'd237);
        convert(8'd5);
        display(8'd5);
        convert(8'd0);
        display(8'd0);
        convert(8'd255);
        for (int k = 0; k < 6; k++) begin
            r = DW'($urandom_range(0, (1 << DW) - 1));
            convert(r);
            if (k < 2) display(r);
        end

        // Back-to-back with an overwritten pending word.
        bc = 0;
        rises = 0;
        prevb = 0;
        bad17 = 0;
        for (int j = 0; j <= 2 * LAT + 3; j++) begin
            @(negedge clk);
            if (j >= 1) begin
                if (busy) bc++;
                if (busy && !prevb) rises++;
                prevb = busy;
                if (j >= LAT + 1 && bcd == to_bcd(mag(8'd17))) bad17 = 1;
                if (j == LAT + 1) chk("b2b_first", bcd, to_bcd(mag(8'd99)));
                if (j == 2 * LAT + 1) begin
                    chk("b2b_second", bcd, to_bcd(mag(8'd200)));
                    chk("b2b_idle", busy, 0);
                end
            end
            done = (j == 0 || j == 3 || j == 4);
            result = (j == 0) ? 8'd99 : (j == 3) ? 8'd17 : 8'd200;
        end
        done = 1'b0;
        chk("b2b_busy_len", bc, 2 * LAT);
        chk("b2b_one_rise", rises, 1);
        chk("b2b_no17", bad17, 0);

        // Reset during a conversion aborts everything.
        @(negedge clk);
        done = 1'b1;
        result = 8'd255;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", valid, 0);
        chk("mid_bcd", bcd, 12'h000);
        chk("mid_an", an, 4'b1111);
        chk("mid_seg", seg, BL);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        convert(8'd1);
        display(8'd1);

`ifdef CALC_SIGNED_EN
        convert(8'hF6);
        display(8'hF6);
        convert(8'h80);
        display(8'h80);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
